vga_pattern_engine: RTL and testbench
=====================================

Name: vga_pattern_engine

Overview:
Parametrised VGA test-pattern generator and successor to the fixed-pattern TinyVGA demo. It contains its own parametrised sync timing, four selectable patterns, and programmable scroll speed and direction. All state is updated synchronously on clk; the scroll counter is no longer clocked from vsync. Outputs are fully registered and aligned to each other, ready for the TinyVGA PMOD pin mapping done at top level.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
COORD_W, 10, width of pixel counters and scroll offset

Ports:
clk  input  1  pixel clock
reset  input  1  asynchronous, active-high reset
cfg_mode  input  2  pattern select: 0 BARS, 1 CHECKER, 2 GRADIENT, 3 SOLID
cfg_speed  input  3  scroll step, in pixels per frame
cfg_dir  input  1  scroll direction: 0 = offset increases, 1 = offset decreases
cfg_sel  input  4  pattern argument (checker bit index, or solid colour)
hsync  output  1  horizontal sync
vsync  output  1  vertical sync
r  output  2  red
g  output  2  green
b  output  2  blue
frame_start  output  1  one-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Counters and sync timing:
  - H_TOTAL = sum of the four H params; V_TOTAL = sum of the four V params.
  - h counts 0..H_TOTAL-1 and wraps. v increments when h wraps and itself wraps at V_TOTAL-1.
  - Line is active when h < H_ACTIVE and v < V_ACTIVE.
  - Sync is asserted (driven to SYNC_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and likewise for v using the V params.
- Output pipeline:
  - Latency is exactly one clk. hsync, vsync, r, g, b and frame_start are all registered from the same (h, v) sample and are mutually aligned.
- Reset (asynchronous): h = 0, v = 0, offset = 0, shadow config = 0, hsync = vsync = !SYNC_POL, r = g = b = 0, frame_start = 0.
  - First rising edge after reset release outputs pixel (0,0) with frame_start = 1.
  - Reset mid-frame aborts the frame immediately; no partial state survives.
- Frame-boundary update, in the cycle where h = H_TOTAL-1 and v = V_TOTAL-1:
  - cfg_mode and cfg_sel are latched into shadow registers.
  - offset updates to offset ± cfg_speed (sign from cfg_dir), modulo 2^COORD_W. Wrap-around is silent.
  - cfg_speed = 0 freezes the pattern.
  - Config changes mid-frame have no visible effect until the next frame.
- Pattern arithmetic:
  - mx = (h + offset) mod 2^COORD_W; y = v.
  - Bit index s = shadow sel, clamped to COORD_W-1.
- Patterns (shadow mode):
  - BARS: idx = mx[7:5]; r = {2{idx[0]}}, g = {2{idx[1]}}, b = {2{idx[2]}}.
  - CHECKER: c = mx[s] ^ y[s]; r = g = b = {2{c}}.
  - GRADIENT: r = mx[7:6], g = y[7:6], b = mx[7:6] ^ y[7:6].
  - SOLID: r = sel[1:0], g = sel[3:2], b = sel[1:0] ^ sel[3:2]. No motion.
- Outside the active region r = g = b = 0 regardless of mode.

Decomposition:
- Package vga_pkg holds:
  - mode enum (MODE_BARS/CHECKER/GRADIENT/SOLID);
  - default 640x480@60 timing constants;
  - H_TOTAL/V_TOTAL helper functions.
- Sub-module vga_timing, which is reused elsewhere in the codebase:
  - contains the h/v counters, the active flag, combinational sync, and the frame_end strobe;
  - outputs are unregistered, and the single output register stage lives in vga_pattern_engine.

Test Plan:
- Default params, release reset -> frame_start at edge 1, repeats every 420000 clks; hsync low for output cycles of h = 656..751 (96 clks); vsync low for lines 490..491.
- SYNC_POL = 1 -> hsync/vsync idle 0 during reset and pulse high with identical timing.
- BARS, speed 0 -> pixel (0..31, 0) gives rgb 0/0/0 and pixel (32, 0) gives r = 3, g = 0, b = 0. With speed 3, dir 0, after 11 frames pixel 0 on line 0 equals pixel 33 of frame 0 (offset 33).
- dir 1, speed 1, from reset -> offset after first frame is 1023 (wraps); pixel (1,0) equals frame-0 pixel (0,0).
- CHECKER sel = 4 -> pixel (16,0) white, pixel (16,16) black; change cfg_mode to SOLID mid-frame -> no change until next frame_start; sel = 4'b0110 then gives r = 2, g = 1, b = 3 in active region and 0 in blanking.
- Assert reset at line 200 mid-line -> outputs are immediately idle and black; after release, frame_start on the first edge and counters restart at (0,0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: pattern modes, default 640x480@60 timing and
// helpers for total line/frame lengths.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int h_total(int act, int fp, int sw, int bp);
        return act + fp + sw + bp;
    endfunction

    function automatic int v_total(int act, int fp, int sw, int bp);
        return act + fp + sw + bp;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running h/v counters with combinational sync, active flag and
// end-of-frame strobe; outputs are unregistered.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int COORD_W  = 10
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] h,
    output logic [COORD_W-1:0] v,
    output logic               active,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_end
);

    localparam int HT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(HT - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(VT - 1);
    localparam logic [COORD_W-1:0] H_ACT  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic               h_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    always_comb begin
        h_wrap = (h_q == H_LAST);
        h_d    = h_wrap ? '0 : h_q + 1'b1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_comb begin
        h         = h_q;
        v         = v_q;
        active    = (h_q < H_ACT) && (v_q < V_ACT);
        hsync     = (h_q >= HS_BEG && h_q < HS_END) ? SYNC_POL : ~SYNC_POL;
        vsync     = (v_q >= VS_BEG && v_q < VS_END) ? SYNC_POL : ~SYNC_POL;
        frame_end = h_wrap && (v_q == V_LAST);
    end

endmodule

// File: rtl/vga_pattern_engine.sv
// VGA test-pattern generator: shadowed config, per-frame scroll offset and
// one registered output stage aligned across sync, colour and frame_start.
module vga_pattern_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int COORD_W  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cfg_mode,
    input  logic [2:0] cfg_speed,
    input  logic       cfg_dir,
    input  logic [3:0] cfg_sel,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       frame_start
);

    localparam logic [3:0] S_MAX = 4'(COORD_W - 1);

    logic [COORD_W-1:0] t_h, t_v;
    logic               t_active, t_hsync, t_vsync, t_frame_end;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .COORD_W  (COORD_W)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .h         (t_h),
        .v         (t_v),
        .active    (t_active),
        .hsync     (t_hsync),
        .vsync     (t_vsync),
        .frame_end (t_frame_end)
    );

    mode_e              mode_q, mode_d;
    logic [3:0]         sel_q, sel_d;
    logic [COORD_W-1:0] off_q, off_d;
    logic [5:0]         rgb_q, rgb_d;
    logic               hsync_q, vsync_q, fs_q;
    logic               fs_d;

    logic [COORD_W-1:0] mx;
    logic [3:0]         s;
    logic [2:0]         idx;
    logic               c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_BARS;
            sel_q   <= '0;
            off_q   <= '0;
            rgb_q   <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            fs_q    <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            rgb_q   <= rgb_d;
            hsync_q <= t_hsync;
            vsync_q <= t_vsync;
            fs_q    <= fs_d;
        end
    end

    // Config and scroll only move at the last pixel of a frame.
    always_comb begin
        mode_d = mode_q;
        sel_d  = sel_q;
        off_d  = off_q;
        if (t_frame_end) begin
            mode_d = mode_e'(cfg_mode);
            sel_d  = cfg_sel;
            off_d  = cfg_dir ? off_q - COORD_W'(cfg_speed)
                             : off_q + COORD_W'(cfg_speed);
        end
    end

    always_comb begin
        mx    = t_h + off_q;
        s     = (sel_q > S_MAX) ? S_MAX : sel_q;
        idx   = mx[7:5];
        c     = mx[s] ^ t_v[s];
        fs_d  = (t_h == '0) && (t_v == '0);
        rgb_d = '0;
        if (t_active) begin
            unique case (mode_q)
                MODE_BARS:     rgb_d = {{2{idx[0]}}, {2{idx[1]}}, {2{idx[2]}}};
                MODE_CHECKER:  rgb_d = {6{c}};
                MODE_GRADIENT: rgb_d = {mx[7:6], t_v[7:6], mx[7:6] ^ t_v[7:6]};
                MODE_SOLID:    rgb_d = {sel_q[1:0], sel_q[3:2], sel_q[1:0] ^ sel_q[3:2]};
            endcase
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign r           = rgb_q[5:4];
    assign g           = rgb_q[3:2];
    assign b           = rgb_q[1:0];
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_engine.sv
// Self-checking bench: two engines (active-low and active-high sync) on a
// reduced raster, compared cycle by cycle against a pixel-formula model.
module tb_vga_pattern_engine;

    localparam int HA = 40, HF = 4, HS = 6, HB = 6;
    localparam int VA = 20, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cfg_mode;
    logic [2:0] cfg_speed;
    logic       cfg_dir;
    logic [3:0] cfg_sel;

    logic       hs0, vs0, fs0, hs1, vs1, fs1;
    logic [1:0] r0, g0, b0, r1, g1, b1;

    int checks = 0;
    int failures = 0;

    // model state: current pixel and the frame's latched config/offset
    int mh, mv, moff, mmode, msel;

    always #5 clk = ~clk;

    vga_pattern_engine #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .COORD_W(10)
    ) u_dut0 (
        .clk(clk), .reset(reset),
        .cfg_mode(cfg_mode), .cfg_speed(cfg_speed),
        .cfg_dir(cfg_dir), .cfg_sel(cfg_sel),
        .hsync(hs0), .vsync(vs0), .r(r0), .g(g0), .b(b0),
        .frame_start(fs0)
    );

    vga_pattern_engine #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .COORD_W(10)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .cfg_mode(cfg_mode), .cfg_speed(cfg_speed),
        .cfg_dir(cfg_dir), .cfg_sel(cfg_sel),
        .hsync(hs1), .vsync(vs1), .r(r1), .g(g1), .b(b1),
        .frame_start(fs1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (h=%0d v=%0d t=%0t)",
                     tag, got, exp, mh, mv, $time);
        end
    endtask

    function automatic logic [8:0] ref_pix(int h, int v, int mode, int sel,
                                           int off, bit pol);
        int mx, s, idx, c, rr, gg, bb;
        bit hon, von, fs;
        mx = (h + off) % 1024;
        s  = (sel > 9) ? 9 : sel;
        rr = 0; gg = 0; bb = 0;
        if (h < HA && v < VA) begin
            case (mode)
                0: begin
                    idx = (mx / 32) % 8;
                    rr = (idx % 2) * 3;
                    gg = ((idx / 2) % 2) * 3;
                    bb = ((idx / 4) % 2) * 3;
                end
                1: begin
                    c = ((mx >> s) & 1) ^ ((v >> s) & 1);
                    rr = c * 3; gg = c * 3; bb = c * 3;
                end
                2: begin
                    rr = (mx / 64) % 4;
                    gg = (v / 64) % 4;
                    bb = rr ^ gg;
                end
                default: begin
                    rr = sel % 4;
                    gg = (sel / 4) % 4;
                    bb = rr ^ gg;
                end
            endcase
        end
        hon = (h >= HA + HF) && (h < HA + HF + HS);
        von = (v >= VA + VF) && (v < VA + VF + VS);
        fs  = (h == 0) && (v == 0);
        return {hon ? pol : !pol, von ? pol : !pol,
                2'(rr), 2'(gg), 2'(bb), fs};
    endfunction

    task automatic model_reset();
        mh = 0; mv = 0; moff = 0; mmode = 0; msel = 0;
    endtask

    task automatic step(input bit rnd);
        logic [8:0] e0, e1;
        bit bars32;
        e0 = ref_pix(mh, mv, mmode, msel, moff, 1'b0);
        e1 = ref_pix(mh, mv, mmode, msel, moff, 1'b1);
        bars32 = (mmode == 0 && moff == 0 && mv == 0 && mh == 32);
        if (mh == HT - 1 && mv == VT - 1) begin
            mmode = int'(cfg_mode);
            msel  = int'(cfg_sel);
            moff  = cfg_dir ? (moff - int'(cfg_speed) + 1024) % 1024
                            : (moff + int'(cfg_speed)) % 1024;
        end
        @(posedge clk);
        #1;
        chk("pix", {hs0, vs0, r0, g0, b0, fs0, hs1, vs1, r1, g1, b1, fs1},
            {e0, e1});
        if (bars32)
            chk("bars32", {r0, g0, b0}, 6'b110000);
        mh = mh + 1;
        if (mh == HT) begin
            mh = 0;
            mv = (mv + 1) % VT;
        end
        if (rnd && $urandom_range(0, 299) == 0) begin
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_speed = 3'($urandom_range(0, 7));
            cfg_dir   = 1'($urandom_range(0, 1));
            cfg_sel   = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic run(input int n, input bit rnd);
        for (int i = 0; i < n; i++) step(rnd);
    endtask

    task automatic check_idle(input string tag);
        chk(tag, {hs0, vs0, r0, g0, b0, fs0, hs1, vs1, r1, g1, b1, fs1},
            {9'b1_1_000000_0, 9'b0_0_000000_0});
    endtask

    initial begin
        int guard;
        reset     = 1'b1;
        cfg_mode  = 2'd0;
        cfg_speed = 3'd1;
        cfg_dir   = 1'b1;
        cfg_sel   = 4'd0;
        #2;
        check_idle("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst_hold");
        reset = 1'b0;
        model_reset();

        // BARS, scrolling backwards by one: offset wraps to 1023
        run(2 * FRAME, 1'b0);

        // CHECKER on bit 4, frozen
        cfg_mode  = 2'd1;
        cfg_sel   = 4'd4;
        cfg_speed = 3'd0;
        run(FRAME + FRAME / 2, 1'b0);

        // mid-frame switch to SOLID only shows from the next frame
        cfg_mode = 2'd3;
        cfg_sel  = 4'b0110;
        run(FRAME, 1'b0);

        // forward scroll by 3
        cfg_mode  = 2'd0;
        cfg_speed = 3'd3;
        cfg_dir   = 1'b0;
        run(2 * FRAME, 1'b0);

        // reset mid-line on line 10
        guard = 0;
        while (!(mv == 10 && mh == 5) && guard < FRAME) begin
            step(1'b0);
            guard++;
        end
        chk("reach_line10", 32'(guard < FRAME), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle("rst_mid_async");
        @(posedge clk);
        #1;
        check_idle("rst_mid_hold");
        reset = 1'b0;
        model_reset();

        cfg_mode  = 2'd2;
        cfg_speed = 3'd7;
        cfg_dir   = 1'b0;
        run(FRAME, 1'b0);

        // randomized config churn
        run(8 * FRAME, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
